cla_result_buffer: RTL and testbench
====================================

// Module: cla_result_buffer
// PURPOSE
//  Downstream stage of the carry-lookahead adder datapath/controller pair.
//  Detects each new completion (rising edge of the controller's done) and
//  captures {cout, sum} into a small FIFO. Results go to the consumer over a
//  valid/ready handshake. Decouples adder completion from a slower sink.
// PARAMETERS
//  N      16  adder operand/sum width; must equal the adder's N
//  DEPTH  4   FIFO entries; power of two, >= 2
//  AW     $clog2(DEPTH)  derived pointer width; local, not overridable
// PORTS
//  clk        in   1      rising-edge clock, shared with the adder controller
//  rst        in   1      asynchronous reset, active-high
//  done       in   1      controller done level; stays high while result held
//  sum_in     in   N      adder sum, valid whenever done=1
//  cout_in    in   1      adder carry-out, valid whenever done=1
//  res_valid  out  1      head entry present (= !empty)
//  res_ready  in   1      consumer accepts head this cycle
//  res_sum    out  N      head entry sum
//  res_cout   out  1      head entry carry
//  count      out  AW+1   occupied entries, 0..DEPTH
//  full       out  1      count==DEPTH
//  empty      out  1      count==0
//  overflow   out  1      sticky: a capture was dropped
//  res_parity out  1      only with CLA_RESULT_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst=1): done_q=0, wr_ptr=rd_ptr=0, count=0, overflow=0,
//    all storage=0. Result: res_valid=0, res_sum=0, res_cout=0, empty=1, full=0.
//  - Capture event: cap = done & ~done_q. done_q <= done every clk.
//    done held high across many cycles gives one capture only.
//    done already high when rst releases: one capture on the first edge.
//  - Pop event: pop = res_valid & res_ready.
//  - Write: on the clk edge where cap=1 and (!full or pop):
//    mem[wr_ptr] <= {cout_in,sum_in}, wr_ptr++ (wraps at DEPTH).
//  - Read: first-word-fall-through. res_sum/res_cout = mem[rd_ptr]
//    (combinational from registered storage). On pop, rd_ptr++ (wraps).
//  - count: +1 on write only; -1 on pop only; unchanged on both or neither.
//  - Occupancy states, derived from count:
//    EMPTY(0) -> PARTIAL on write.
//    PARTIAL -> FULL when a write makes count==DEPTH.
//    PARTIAL -> EMPTY when a pop makes count==0.
//    FULL -> PARTIAL on pop without write.
//  - Latency: done rises before edge k -> entry written at edge k;
//    res_valid=1 after edge k. No same-cycle bypass when empty.
//  - Full + cap + pop on the same edge: write accepted; count stays DEPTH.
//  - Full + cap without pop: entry dropped; overflow <= 1. overflow clears
//    only on rst.
//  - Empty + res_ready: no effect; pointers unchanged.
//  - rst mid-operation: all state and contents discarded immediately,
//    asynchronously.
// CONFIGURATION
//  CLA_RESULT_PARITY_EN defined:
//    - Each entry stores an extra bit = ^{cout_in,sum_in}, computed at capture.
//    - res_parity presents the head entry's bit; reset value 0.
//  CLA_RESULT_PARITY_EN undefined:
//    - No res_parity port, no extra storage bit.
//    - All other behaviour is identical.
// TESTING
//  1 rst=1 then release, done=0 -> res_valid=0, count=0, empty=1,
//    overflow=0, res_sum=0.
//  2 sum_in=16'h1234, cout_in=1; done 0->1, held 5 cycles, res_ready=0
//    -> exactly one entry: count=1, res_sum=1234, res_cout=1.
//  3 Five done pulses (sums 1..5), res_ready=0, DEPTH=4 -> full=1, count=4,
//    overflow=1. Drain: reads 1,2,3,4, then empty=1.
//  4 Full FIFO, res_ready=1 and new done edge with sum 16'hAAAA on the same
//    edge -> count stays 4; AAAA is read last after the 4 older entries.
//  5 rst pulsed while count=3 and done=1 -> immediately count=0,
//    res_valid=0. After release with done still 1 -> one capture, count=1.
//  6 CLA_RESULT_PARITY_EN: capture sum 16'h0007, cout 0 -> res_parity=1;
//    sum 16'h0003, cout 0 -> res_parity=0.

Source files
------------

// File: rtl/cla_result_buffer.sv
// cla_result_buffer: captures each completion of the carry-lookahead adder
// ({cout, sum}) on the rising edge of the controller's done level into a small
// first-word-fall-through FIFO, and presents results over valid/ready.
// Optional feature: define CLA_RESULT_PARITY_EN to store a per-entry parity
// bit and expose it on res_parity.
module cla_result_buffer #(
  parameter  int N     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [N-1:0]  sum_in,
  input  logic          cout_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_sum,
  output logic          res_cout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow
`ifdef CLA_RESULT_PARITY_EN
  ,
  output logic          res_parity
`endif
);

`ifdef CLA_RESULT_PARITY_EN
  localparam int EW = N + 2;
`else
  localparam int EW = N + 1;
`endif

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_e;

  occ_e          state_q, state_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic          cap;
  logic          pop;
  logic          wr;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;

  // Entry to store on capture: {cout, sum}, with parity on top when enabled.
  always_comb begin
`ifdef CLA_RESULT_PARITY_EN
    entry_in = {^{cout_in, sum_in}, cout_in, sum_in};
`else
    entry_in = {cout_in, sum_in};
`endif
  end

  // Capture/pop/write events; a full FIFO still accepts when the head leaves on the same edge.
  always_comb begin
    cap = done & ~done_q;
    pop = res_valid & res_ready;
    wr  = cap & (~full | pop);
  end

  // Datapath next state: storage, pointers, occupancy count, sticky overflow.
  always_comb begin
    done_d     = done;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (cap & full & ~pop);
    if (wr) begin
      mem_d[wr_ptr_q] = entry_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Occupancy FSM next state; tracks the same transitions as count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (wr) state_d = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (wr && !pop && count_q == DEPTH_C - CNT_ONE) state_d = S_FULL;
        else if (pop && !wr && count_q == CNT_ONE)       state_d = S_EMPTY;
      end
      S_FULL: begin
        if (pop && !wr) state_d = S_PARTIAL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State registers with asynchronous clear of all state and storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Fall-through read of the head entry and status outputs.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    res_sum   = head[N-1:0];
    res_cout  = head[N];
    empty     = (state_q == S_EMPTY);
    full      = (state_q == S_FULL);
    res_valid = ~empty;
    count     = count_q;
    overflow  = overflow_q;
`ifdef CLA_RESULT_PARITY_EN
    res_parity = head[N+1];
`endif
  end

endmodule

// File: tb/tb_cla_result_buffer.sv
// Bench for cla_result_buffer: a queue-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_cla_result_buffer;
  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  logic [N-1:0]  sum_in;
  logic          cout_in;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_sum;
  logic          res_cout;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef CLA_RESULT_PARITY_EN
  logic          res_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef CLA_RESULT_PARITY_EN
    ,
    .res_parity(res_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {cout,sum}, previous done level, sticky overflow.
  logic [N:0] mq[$];
  logic       m_done_prev;
  logic       m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_done_prev = 1'b0;
      m_ovf       = 1'b0;
    end else begin
      if (mq.size() > 0 && res_ready) void'(mq.pop_front());
      if (done && !m_done_prev) begin
        if (mq.size() < DEPTH) mq.push_back({cout_in, sum_in});
        else m_ovf = 1'b1;
      end
      m_done_prev = done;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("m_valid", 32'(res_valid), 32'(mq.size() > 0));
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_full",  32'(full),  32'(mq.size() == DEPTH));
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_ovf",   32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        check("m_sum",  32'(res_sum),  32'(mq[0][N-1:0]));
        check("m_cout", 32'(res_cout), 32'(mq[0][N]));
`ifdef CLA_RESULT_PARITY_EN
        check("m_par", 32'(res_parity), 32'(^mq[0]));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] s, input logic c);
    sum_in = s; cout_in = c; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; sum_in = '0; cout_in = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // 1: reset state
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_sum",   32'(res_sum), 32'd0);

    // 2: done held high gives one capture
    sum_in = 16'h1234; cout_in = 1'b1; done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    done = 1'b0;
    tick();
    check("hold_count", 32'(count), 32'd1);
    check("hold_sum",   32'(res_sum), 32'h1234);
    check("hold_cout",  32'(res_cout), 32'd1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("hold_drained", 32'(empty), 32'd1);

    // 3: overflow then drain in order
    for (int i = 1; i <= 5; i++) pulse(16'(i), 1'b0);
    check("ovf_full",  32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_sum", 32'(res_sum), 32'(i));
      tick();
    end
    res_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("empty_ready_count", 32'(count), 32'd0);

    // 4: full + capture + pop on the same edge
    for (int i = 0; i < 4; i++) pulse(16'h0010 + 16'(i), 1'b1);
    check("fp_full", 32'(full), 32'd1);
    check("fp_head", 32'(res_sum), 32'h0010);
    res_ready = 1'b1; sum_in = 16'hAAAA; cout_in = 1'b0; done = 1'b1;
    tick();
    done = 1'b0;
    check("fp_count", 32'(count), 32'd4);
    for (int i = 1; i <= 3; i++) begin
      check("fp_old", 32'(res_sum), 32'h0010 + 32'(i));
      tick();
    end
    check("fp_last", 32'(res_sum), 32'hAAAA);
    check("fp_last_cout", 32'(res_cout), 32'd0);
    tick();
    res_ready = 1'b0;
    check("fp_empty", 32'(empty), 32'd1);
    check("fp_ovf_sticky", 32'(overflow), 32'd1);

    // 5: asynchronous reset mid-operation, done still high at release
    pulse(16'h0101, 1'b0);
    pulse(16'h0202, 1'b0);
    sum_in = 16'h0303; done = 1'b1;
    tick();
    check("ar_count_pre", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_valid", 32'(res_valid), 32'd0);
    check("ar_ovf",   32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_recap", 32'(count), 32'd1);
    check("ar_sum",   32'(res_sum), 32'h0303);
    tick();
    check("ar_once", 32'(count), 32'd1);
    done = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;

`ifdef CLA_RESULT_PARITY_EN
    // 6: parity of stored entries
    pulse(16'h0007, 1'b0);
    check("par_odd", 32'(res_parity), 32'd1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    pulse(16'h0003, 1'b0);
    check("par_even", 32'(res_parity), 32'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
